cond_unit: RTL
==============

Name: cond_unit

Overview:
- Conditional-execution stage directly downstream of the multicycle main control FSM.
- Consumes the FSM's per-state write intents (RegW, MemW, NextPC, Branch) together with FlagW and PCS from the ALU/PC decode.
- Holds the architectural NZCV flags and evaluates the instruction's 4-bit condition field. Drives the final PCWrite/RegWrite/MemWrite strobes to the datapath.
- Also keeps executed/squashed instruction counters for bring-up debug.

Parameters:
- CNT_W, 16, width of the executed and squashed instruction counters.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- Cond  input  4  condition field, Instr[31:28]
- ALUFlags  input  4  {N,Z,C,V} from the ALU, current cycle
- FlagW  input  2  flag write request: [1] updates N,Z; [0] updates C,V
- PCS  input  1  instruction writes PC (branch or Rd==15)
- NextPC  input  1  unconditional PC increment strobe from the FSM
- RegW  input  1  register-file write intent from the FSM
- MemW  input  1  memory write intent from the FSM
- InstrDone  input  1  one-cycle pulse in the last cycle of each instruction
- CntClr  input  1  synchronous clear of both counters
- PCWrite  output  1  final PC write enable
- RegWrite  output  1  final register-file write enable
- MemWrite  output  1  final memory write enable
- Flags  output  4  architectural {N,Z,C,V}
- CondExD  output  1  registered condition result
- ExecCnt  output  CNT_W  instructions retired with the condition passed
- SquashCnt  output  CNT_W  instructions retired with the condition failed

Behaviour:
- Reset (asynchronous, any cycle, including mid-instruction): Flags=0000, CondExD=0, ExecCnt=0, SquashCnt=0.
  - The outputs then follow combinationally: PCWrite=NextPC, RegWrite=0, MemWrite=0.
- CondEx is combinational from Cond and the registered Flags; it never uses ALUFlags.
  - 0 EQ: Z. 1 NE: ~Z. 2 CS: C. 3 CC: ~C. 4 MI: N. 5 PL: ~N. 6 VS: V. 7 VC: ~V.
  - 8 HI: C&~Z. 9 LS: ~C|Z. A GE: N==V. B LT: N!=V. C GT: ~Z&(N==V). D LE: Z|(N!=V).
  - E AL: 1. F: 1 (unconditional).
- CondExD register:
  - Loads CondEx on every rising edge.
  - Gives the FSM's execute/writeback states the condition evaluated one cycle earlier, i.e. in DECODE.
- Flag update, on the rising edge:
  - FlagWrite[1] = FlagW[1] & CondEx. When high, Flags[3:2] <= ALUFlags[3:2].
  - FlagWrite[0] = FlagW[0] & CondEx. When high, Flags[1:0] <= ALUFlags[1:0].
  - The two halves are independent. A failed condition leaves all flags unchanged.
- Simultaneous flag write and evaluation:
  - CondEx and CondExD capture use the pre-edge Flags.
  - New flags are visible to CondEx starting the cycle after the write.
- Output gating (combinational, zero latency):
  - PCWrite = NextPC | (PCS & CondExD).
  - RegWrite = RegW & CondExD.
  - MemWrite = MemW & CondExD.
  - NextPC is never gated, so fetch always advances.
- Counters, on a rising edge with InstrDone=1:
  - If CondExD=1, ExecCnt increments; otherwise SquashCnt increments.
  - Exactly one counter changes per InstrDone pulse.
  - Counters wrap modulo 2^CNT_W: all-ones +1 gives 0.
  - CntClr has priority over an increment in the same cycle; both counters become 0.
  - CntClr does not affect Flags or CondExD.
- X-safety:
  - With RegW=MemW=PCS=NextPC=0, all three write outputs are 0 regardless of CondExD.
  - FlagW=00 never changes Flags.

Test Plan:
- After reset, drive Cond=0000 (EQ), RegW=1 for 2 cycles -> CondExD=0, RegWrite=0; then Cond=1110 -> RegWrite=1 one cycle later.
- Cond=1110, ALUFlags=0100, FlagW=10 for one edge -> Flags=0100. Next cycle Cond=0000 -> CondEx=1, and CondExD=1 on the following edge.
- Flags=1000, Cond=1010 (GE), FlagW=11, ALUFlags=0001 -> CondEx=0, so Flags stay 1000. With Cond=1110 the same stimulus -> Flags=0001.
- Cond=1011 (LT), Flags=1000, PCS=1, NextPC=0 -> after one edge PCWrite=1. Flags=1001 -> PCWrite=0. NextPC=1 -> PCWrite=1 regardless.
- 3 InstrDone pulses with CondExD=1 and 2 with CondExD=0 -> ExecCnt=3, SquashCnt=2. With CNT_W=4 and ExecCnt=15, one pulse -> 0. CntClr with InstrDone in the same cycle -> both counters 0.
- Assert reset mid-write (MemW=1, CondExD=1, Flags=1111) -> Flags=0000, CondExD=0, and MemWrite=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cond_unit.sv
// ----------------------------------------------------------------------------
// cond_unit
// Conditional-execution stage that sits after the multicycle main control FSM.
// Holds the architectural NZCV flags, evaluates the instruction condition
// field against them, and gates the FSM write intents into the final
// PC / register-file / memory write strobes. Also counts retired
// instructions, split into executed and squashed, for bring-up debug.
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   reset      asynchronous active-high reset, clears all state
//   Cond       condition field Instr[31:28]
//   ALUFlags   {N,Z,C,V} produced by the ALU this cycle
//   FlagW      flag write request: [1] -> N,Z   [0] -> C,V
//   PCS        instruction writes the PC (branch or Rd==15)
//   NextPC     unconditional PC increment strobe from the FSM
//   RegW       register-file write intent from the FSM
//   MemW       memory write intent from the FSM
//   InstrDone  one-cycle pulse in the last cycle of each instruction
//   CntClr     synchronous clear of both debug counters
//   PCWrite    final PC write enable
//   RegWrite   final register-file write enable
//   MemWrite   final memory write enable
//   Flags      architectural {N,Z,C,V}
//   CondExD    condition result registered one cycle earlier
//   ExecCnt    instructions retired with the condition passed
//   SquashCnt  instructions retired with the condition failed
// ----------------------------------------------------------------------------
module cond_unit #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       Cond,
   input  logic [3:0]       ALUFlags,
   input  logic [1:0]       FlagW,
   input  logic             PCS,
   input  logic             NextPC,
   input  logic             RegW,
   input  logic             MemW,
   input  logic             InstrDone,
   input  logic             CntClr,
   output logic             PCWrite,
   output logic             RegWrite,
   output logic             MemWrite,
   output logic [3:0]       Flags,
   output logic             CondExD,
   output logic [CNT_W-1:0] ExecCnt,
   output logic [CNT_W-1:0] SquashCnt
);

   logic [3:0]       r_flags;
   logic             r_cond_ex_d;
   logic [CNT_W-1:0] r_exec_cnt;
   logic [CNT_W-1:0] r_squash_cnt;

   logic             w_n;
   logic             w_z;
   logic             w_c;
   logic             w_v;
   logic             w_cond_ex;
   logic [1:0]       w_flag_write;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   assign {w_n, w_z, w_c, w_v} = r_flags;

   // Condition is evaluated only against the architectural (registered)
   // flags, never against the ALU result of the current cycle.
   always_comb begin
      w_cond_ex = 1'b1;
      case (Cond)
         4'h0:    w_cond_ex = w_z;
         4'h1:    w_cond_ex = ~w_z;
         4'h2:    w_cond_ex = w_c;
         4'h3:    w_cond_ex = ~w_c;
         4'h4:    w_cond_ex = w_n;
         4'h5:    w_cond_ex = ~w_n;
         4'h6:    w_cond_ex = w_v;
         4'h7:    w_cond_ex = ~w_v;
         4'h8:    w_cond_ex = w_c & ~w_z;
         4'h9:    w_cond_ex = ~w_c | w_z;
         4'hA:    w_cond_ex = (w_n == w_v);
         4'hB:    w_cond_ex = (w_n != w_v);
         4'hC:    w_cond_ex = ~w_z & (w_n == w_v);
         4'hD:    w_cond_ex = w_z | (w_n != w_v);
         default: w_cond_ex = 1'b1;
      endcase
   end

   assign w_flag_write = FlagW & {2{w_cond_ex}};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_flags      <= 4'b0000;
         r_cond_ex_d  <= 1'b0;
         r_exec_cnt   <= '0;
         r_squash_cnt <= '0;
      end else begin
         // Captured with the pre-edge flags, so a flag write in the same
         // cycle is seen by the condition only from the next cycle on.
         r_cond_ex_d <= w_cond_ex;
         if (w_flag_write[1]) r_flags[3:2] <= ALUFlags[3:2];
         if (w_flag_write[0]) r_flags[1:0] <= ALUFlags[1:0];
         // Clear wins over an increment arriving in the same cycle.
         if (CntClr) begin
            r_exec_cnt   <= '0;
            r_squash_cnt <= '0;
         end else if (InstrDone) begin
            if (r_cond_ex_d) r_exec_cnt   <= r_exec_cnt + CNT_ONE;
            else             r_squash_cnt <= r_squash_cnt + CNT_ONE;
         end
      end
   end

   // NextPC bypasses the condition so that fetch always advances.
   assign PCWrite   = NextPC | (PCS & r_cond_ex_d);
   assign RegWrite  = RegW & r_cond_ex_d;
   assign MemWrite  = MemW & r_cond_ex_d;
   assign Flags     = r_flags;
   assign CondExD   = r_cond_ex_d;
   assign ExecCnt   = r_exec_cnt;
   assign SquashCnt = r_squash_cnt;

endmodule
